snn_lif_core: RTL and testbench



---
 rtl/snn_pkg.sv | 27 ++
 rtl/snn_lif_neuron.sv | 47 ++++
 rtl/snn_lif_core.sv | 52 +++++
 tb/tb_snn_lif_core.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types, default parameters and the membrane saturation helper
// for the leaky integrate-and-fire spiking core.
package snn_pkg;

  localparam int unsigned F_DEF     = 48;
  localparam int unsigned N_DEF     = 96;
  localparam int unsigned Q_DEF     = 14;
  localparam int unsigned ALPHA_DEF = 15474;
  localparam int unsigned VW        = 24;

  typedef logic signed [15:0]   weight_t;
  typedef logic signed [VW-1:0] membrane_t;

  // Clamp a two-bit-wider signed sum into the membrane range.
  function automatic membrane_t sat_vw(input logic signed [VW+1:0] x);
    membrane_t r;
    if ((x[VW+1:VW-1] == 3'b000) || (x[VW+1:VW-1] == 3'b111)) begin
      r = x[VW-1:0];
    end else if (x[VW+1]) begin
      r = {1'b1, {(VW-1){1'b0}}};
    end else begin
      r = {1'b0, {(VW-1){1'b1}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/snn_lif_neuron.sv
// One LIF neuron: floor-rounded leak, synaptic add with saturation,
// threshold compare, and membrane/spike registers.
module snn_lif_neuron
  import snn_pkg::*;
#(
  parameter int unsigned Q     = Q_DEF,
  parameter int unsigned ALPHA = ALPHA_DEF,
  parameter int unsigned SW    = 23
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic signed [SW-1:0] syn_s,
  input  weight_t              vth,
  output logic                 spike
);

  localparam logic [15:0] ALPHA_W = 16'(ALPHA);

  membrane_t               v_r;
  logic signed [VW+15:0]   prod_s;
  membrane_t               leak_s;
  logic signed [VW+1:0]    sum_s;
  membrane_t               vnew_s;
  logic                    fire_s;

  // Leak, integrate, saturate and compare for this timestep.
  always_comb begin
    prod_s = $signed({{16{v_r[VW-1]}}, v_r}) * $signed({{VW{1'b0}}, ALPHA_W});
    leak_s = membrane_t'(prod_s >>> Q);
    sum_s  = $signed({{2{leak_s[VW-1]}}, leak_s})
           + $signed({{(VW+2-SW){syn_s[SW-1]}}, syn_s});
    vnew_s = sat_vw(sum_s);
    fire_s = (vnew_s >= $signed({{(VW-16){vth[15]}}, vth}));
  end

  // Membrane and spike state; a fire resets the membrane to zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_r   <= '0;
      spike <= 1'b0;
    end else begin
      v_r   <= fire_s ? membrane_t'(0) : vnew_s;
      spike <= fire_s;
    end
  end

endmodule

// File: rtl/snn_lif_core.sv
// Single-layer LIF spiking core: weight/threshold ROMs, per-neuron
// synaptic sums over active events, and N neuron instances.
module snn_lif_core
  import snn_pkg::*;
#(
  parameter int unsigned F         = F_DEF,
  parameter int unsigned N         = N_DEF,
  parameter int unsigned Q         = Q_DEF,
  parameter int unsigned ALPHA_Q14 = ALPHA_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [F-1:0] event_vec,
  output logic [N-1:0] spikes_vec
);

  // Wide enough that F full-scale weights sum exactly.
  localparam int unsigned SW = 16 + $clog2(F) + 1;

  // Preloaded by the environment; contents survive reset.
  weight_t weights_rom [0:F*N-1] = '{default: 16'sd0};
  weight_t vth_rom     [0:N-1]   = '{default: 16'sd0};

  for (genvar n = 0; n < N; n++) begin : gen_neuron
    logic signed [SW-1:0] syn_s;

    // Sum the weights of every active input onto this neuron.
    always_comb begin
      syn_s = '0;
      for (int i = 0; i < F; i++) begin
        if (event_vec[i]) begin
          syn_s = syn_s + SW'(weights_rom[i*N+n]);
        end else begin
          syn_s = syn_s;
        end
      end
    end

    snn_lif_neuron #(
      .Q     (Q),
      .ALPHA (ALPHA_Q14),
      .SW    (SW)
    ) u_neuron (
      .clk   (clk),
      .rstn  (rstn),
      .syn_s (syn_s),
      .vth   (vth_rom[n]),
      .spike (spikes_vec[n])
    );
  end

endmodule

// File: tb/tb_snn_lif_core.sv
// Self-checking bench for snn_lif_core: directed scenarios plus random
// timesteps compared against an integer-arithmetic LIF model.
module tb_snn_lif_core;

  localparam int F = 48;
  localparam int N = 96;
  localparam longint ALPHA = 15474;
  localparam longint VMAX = 64'sd8388607;
  localparam longint VMIN = -64'sd8388608;

  logic         clk;
  logic         rstn;
  logic [F-1:0] event_vec;
  logic [N-1:0] spikes_vec;

  int n_checks;
  int n_fail;

  int     m_w  [F*N];
  int     m_th [N];
  longint m_v  [N];
  logic [N-1:0] m_spk;

  snn_lif_core dut (
    .clk        (clk),
    .rstn       (rstn),
    .event_vec  (event_vec),
    .spikes_vec (spikes_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_w(input int i, input int n, input int val);
    m_w[i*N+n] = val;
    dut.weights_rom[i*N+n] = 16'(val);
  endtask

  task automatic set_th(input int n, input int val);
    m_th[n] = val;
    dut.vth_rom[n] = 16'(val);
  endtask

  task automatic clear_roms(input int th);
    for (int i = 0; i < F; i++)
      for (int n = 0; n < N; n++) set_w(i, n, 0);
    for (int n = 0; n < N; n++) set_th(n, th);
  endtask

  task automatic model_clear();
    for (int n = 0; n < N; n++) m_v[n] = 0;
    m_spk = '0;
  endtask

  // One timestep of the LIF rules using plain integer arithmetic.
  task automatic model_step(input logic [F-1:0] ev);
    longint p, leak, syn, vn;
    for (int n = 0; n < N; n++) begin
      p = m_v[n] * ALPHA;
      if (p >= 0) leak = p / 16384;
      else        leak = -((-p + 16383) / 16384);
      syn = 0;
      for (int i = 0; i < F; i++) if (ev[i]) syn += m_w[i*N+n];
      vn = leak + syn;
      if (vn > VMAX) vn = VMAX;
      if (vn < VMIN) vn = VMIN;
      m_spk[n] = (vn >= m_th[n]);
      m_v[n]   = m_spk[n] ? 0 : vn;
    end
  endtask

  // Called at a negedge: drive, clock, compare at the next negedge.
  task automatic step(input logic [F-1:0] ev, input string tag);
    event_vec = ev;
    @(posedge clk);
    model_step(ev);
    @(negedge clk);
    check(tag, 128'(spikes_vec), 128'(m_spk));
  endtask

  task automatic do_reset();
    event_vec = '0;
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_clear();
    rstn = 1'b1;
  endtask

  logic [F-1:0] b0;
  logic [F-1:0] ones;
  longint       exp_v0 [6] = '{100, 194, 0, 100, 194, 0};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    b0   = '0;
    b0[0] = 1'b1;
    ones = '1;
    rstn = 1'b0;
    event_vec = '0;
    model_clear();
    #1;
    clear_roms(30000);

    // Reset hold with arbitrary events
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      event_vec = F'({$urandom(), $urandom()});
      @(negedge clk);
      check("rst_hold", 128'(spikes_vec), 128'(0));
    end
    for (int n = 0; n < N; n++) set_th(n, 1);
    model_clear();
    event_vec = '0;
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) step('0, "post_rst_quiet");
    set_th(11, 0);
    step('0, "vth_zero_fires");
    step('0, "vth_zero_fires2");

    // Integration and fire on neuron 0
    clear_roms(30000);
    set_w(0, 0, 100);
    set_th(0, 250);
    do_reset();
    for (int t = 0; t < 6; t++) begin
      step(b0, "int_fire");
      check("int_v0", 128'($signed(dut.gen_neuron[0].u_neuron.v_r)), 128'(exp_v0[t]));
    end

    // Async reset mid-cycle while a spike is asserted
    step(b0, "pre_async1");
    step(b0, "pre_async2");
    step(b0, "pre_async3");
    #2 rstn = 1'b0;
    #1 check("async_spk", 128'(spikes_vec), 128'(0));
    @(negedge clk);
    model_clear();
    rstn = 1'b1;
    step(b0, "restart1");
    check("restart_v0", 128'($signed(dut.gen_neuron[0].u_neuron.v_r)), 128'(100));
    step(b0, "restart2");
    #2 rstn = 1'b0;
    #1 check("async_v0", 128'($signed(dut.gen_neuron[0].u_neuron.v_r)), 128'(0));
    @(negedge clk);
    model_clear();
    rstn = 1'b1;

    // Leak on neuron 3, floor rounding on neuron 7
    clear_roms(30000);
    set_w(0, 3, 1000);
    set_w(0, 7, -100);
    do_reset();
    step(b0, "leak_t0");
    check("leak_v3_t0", 128'($signed(dut.gen_neuron[3].u_neuron.v_r)), 128'(1000));
    check("neg_v7_t0", 128'($signed(dut.gen_neuron[7].u_neuron.v_r)), 128'(-100));
    step('0, "leak_t1");
    check("leak_v3_t1", 128'($signed(dut.gen_neuron[3].u_neuron.v_r)), 128'(944));
    check("neg_v7_t1", 128'($signed(dut.gen_neuron[7].u_neuron.v_r)), 128'(-95));
    step('0, "leak_t2");
    check("leak_v3_t2", 128'($signed(dut.gen_neuron[3].u_neuron.v_r)), 128'(891));

    // Full fan-in on neuron 5
    clear_roms(30000);
    for (int i = 0; i < F; i++) set_w(i, 5, 1);
    set_th(5, 48);
    do_reset();
    step(ones, "fanin48_t0");
    step(ones, "fanin48_t1");
    set_th(5, 49);
    do_reset();
    step(ones, "fanin49_t0");
    step(ones, "fanin49_t1");

    // Negative saturation on neuron 9
    clear_roms(30000);
    for (int i = 0; i < F; i++) set_w(i, 9, -32768);
    set_th(9, 32767);
    do_reset();
    for (int t = 0; t < 20; t++) step(ones, "sat_neg");
    check("sat_v9", 128'($signed(dut.gen_neuron[9].u_neuron.v_r)), 128'(VMIN));
    for (int i = 0; i < F; i++) set_w(i, 9, 32767);
    for (int t = 0; t < 12; t++) step(ones, "sat_recover");

    // Randomised weights, thresholds and events
    for (int i = 0; i < F; i++)
      for (int n = 0; n < N; n++) set_w(i, n, int'($urandom_range(65535)) - 32768);
    for (int n = 0; n < N; n++) set_th(n, int'($urandom_range(40000)) - 8000);
    do_reset();
    for (int t = 0; t < 200; t++) begin
      if (t % 3 == 0) step(F'({$urandom(), $urandom()}), "rand");
      else            step(F'({$urandom(), $urandom()}) & F'({$urandom(), $urandom()})
                           & F'({$urandom(), $urandom()}), "rand_sparse");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
